// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder sequencer: state encoding and default width.
package serial_add_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  localparam int unsigned SERIAL_ADD_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/add_bit_slice.sv
// One full-adder bit built from two half adders; carry out is the OR of both half carries.
module add_bit_slice (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);

  logic w_s1;
  logic w_c1;
  logic w_c2;

  half_add u_half_add_ab (
    .i_a    (i_a),
    .i_b    (i_b),
    .o_sum  (w_s1),
    .o_carry(w_c1)
  );

  half_add u_half_add_cin (
    .i_a    (w_s1),
    .i_b    (i_cin),
    .o_sum  (o_sum),
    .o_carry(w_c2)
  );

  assign o_cout = w_c1 | w_c2;

endmodule

// File: rtl/half_add.sv
// Half adder: the building block of the shared full-adder slice.
module half_add (
  input  logic i_a,
  input  logic i_b,
  output logic o_sum,
  output logic o_carry
);

  assign o_sum   = i_a ^ i_b;
  assign o_carry = i_a & i_b;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add sequencer around one shared full-adder slice, LSB first, one bit per clock.
// Optional subtract mode is built when SERIAL_SUB_EN is defined.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = SERIAL_ADD_DEFAULT_WIDTH
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
`ifdef SERIAL_SUB_EN
  input  logic             Sub,
`endif
  output logic             Ready,
  output logic             Done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);

  localparam int unsigned CNTW = $clog2(WIDTH);
  localparam logic [CNTW-1:0] LastBit = CNTW'(WIDTH - 1);

  state_t           r_state;
  logic [CNTW-1:0]  r_cnt;
  logic             r_carry;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  state_t           w_state_nxt;
  logic [CNTW-1:0]  w_cnt_nxt;
  logic             w_carry_nxt;
  logic [WIDTH-1:0] w_a_nxt;
  logic [WIDTH-1:0] w_b_nxt;
  logic [WIDTH-1:0] w_res_nxt;
  logic [WIDTH-1:0] w_sum_nxt;
  logic             w_cout_nxt;

  logic [WIDTH-1:0] w_b_load;
  logic             w_cin_load;
  logic             w_slice_sum;
  logic             w_slice_cout;
  logic [WIDTH-1:0] w_res_shift;

`ifdef SERIAL_SUB_EN
  // Subtraction as A + ~B + 1: invert B on load and seed the carry.
  assign w_b_load   = Sub ? ~B : B;
  assign w_cin_load = Sub;
`else
  assign w_b_load   = B;
  assign w_cin_load = 1'b0;
`endif

  add_bit_slice u_add_bit_slice (
    .i_a   (r_a[0]),
    .i_b   (r_b[0]),
    .i_cin (r_carry),
    .o_sum (w_slice_sum),
    .o_cout(w_slice_cout)
  );

  assign w_res_shift = {w_slice_sum, r_res[WIDTH-1:1]};

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_carry_nxt = r_carry;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_res_nxt   = r_res;
    w_sum_nxt   = r_sum;
    w_cout_nxt  = r_cout;
    case (r_state)
      ST_IDLE: begin
        if (Start) begin
          w_state_nxt = ST_RUN;
          w_a_nxt     = A;
          w_b_nxt     = w_b_load;
          w_carry_nxt = w_cin_load;
          w_cnt_nxt   = '0;
        end
      end
      ST_RUN: begin
        w_a_nxt     = r_a >> 1;
        w_b_nxt     = r_b >> 1;
        w_res_nxt   = w_res_shift;
        w_carry_nxt = w_slice_cout;
        w_cnt_nxt   = r_cnt + 1'b1;
        // Visible result only changes when the last bit has been produced.
        if (r_cnt == LastBit) begin
          w_state_nxt = ST_DONE;
          w_sum_nxt   = w_res_shift;
          w_cout_nxt  = w_slice_cout;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_carry <= w_carry_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_res   <= w_res_nxt;
      r_sum   <= w_sum_nxt;
      r_cout  <= w_cout_nxt;
    end
  end

  assign Ready = (r_state == ST_IDLE);
  assign Done  = (r_state == ST_DONE);
  assign Sum   = r_sum;
  assign Cout  = r_cout;

endmodule
